// File: rtl/core_pkg.sv
// Shared core definitions: machine word width and the skid-buffer state encoding,
// visible to hazard/stall logic that inspects buffer occupancy.
package core_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  // Words held for a given state; the unused encoding reports zero.
  function automatic logic [1:0] occupancy_of(input skid_state_t s);
    case (s)
      BUSY:    occupancy_of = 2'd1;
      FULL:    occupancy_of = 2'd2;
      default: occupancy_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/stall_skid_buffer.sv
// Two-entry valid/ready skid buffer. in_ready is registered so a downstream stall
// never reaches the upstream stage combinationally; one extra word is absorbed in skid.
module stall_skid_buffer
  import core_pkg::*;
#(
  parameter int unsigned WIDTH = XLEN
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  skid_state_t      state_q, state_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [1:0]       occ_q;

  logic in_fire;
  logic out_fire;

  assign in_fire  = in_valid && in_ready_q;
  assign out_fire = out_valid_q && out_ready;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;

    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          head_d  = in_data;
          state_d = BUSY;
        end
      end
      BUSY: begin
        case ({in_fire, out_fire})
          2'b11: head_d = in_data;
          2'b10: begin
            skid_d  = in_data;
            state_d = FULL;
          end
          2'b01:   state_d = EMPTY;
          default: state_d = BUSY;
        endcase
      end
      FULL: begin
        // in_ready is low here, so only the drain path exists.
        if (out_fire) begin
          head_d  = skid_q;
          state_d = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase

    // A redirect drops everything; data registers keep their contents since
    // out_valid is low afterwards and nothing can expose them.
    if (flush) begin
      state_d = EMPTY;
      head_d  = head_q;
      skid_d  = skid_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  // NOTE: head/skid are reset as well, because out_data is observable at reset and
  // must read as zero rather than an unknown value.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= EMPTY;
      head_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      occ_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      skid_q      <= skid_d;
      in_ready_q  <= (state_d != FULL);
      out_valid_q <= (state_d != EMPTY);
      occ_q       <= occupancy_of(state_d);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = head_q;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_stall_skid_buffer.sv
// Directed self-checking bench for stall_skid_buffer: reset, streaming, stall,
// simultaneous handshake, flush and asynchronous reset scenarios.
module tb_stall_skid_buffer;
  import core_pkg::*;

  logic            clock;
  logic            reset;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_data;
  logic [1:0]      occupancy;

  int n_cmp = 0;
  int n_err = 0;

  stall_skid_buffer #(.WIDTH(XLEN)) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h77;
    out_ready = 1'b0;
    step();
    step();
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL rst_occupancy: got %0d want 0", occupancy); end
    n_cmp++; if (out_data !== 32'h0) begin n_err++; $display("FAIL rst_out_data: got %h want 0", out_data); end
    in_valid = 1'b0;
    reset    = 1'b1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rel_in_ready_early: got %b want 0", in_ready); end
    step();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rel_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rel_out_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_streaming();
    logic [XLEN-1:0] words [3];
    words[0] = 32'h1;
    words[1] = 32'h2;
    words[2] = 32'h3;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = words[i];
      step();
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL stream_valid[%0d]: got %b want 1", i, out_valid); end
      n_cmp++; if (out_data !== words[i]) begin n_err++; $display("FAIL stream_data[%0d]: got %h want %h", i, out_data, words[i]); end
      n_cmp++; if (occupancy !== 2'd1) begin n_err++; $display("FAIL stream_occ[%0d]: got %0d want 1", i, occupancy); end
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stream_in_ready[%0d]: got %b want 1", i, in_ready); end
    end
    in_valid = 1'b0;
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stream_drain_valid: got %b want 0", out_valid); end
    n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL stream_drain_occ: got %0d want 0", occupancy); end
  endtask

  task automatic test_stall_absorb();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA;
    step();
    n_cmp++; if (occupancy !== 2'd1) begin n_err++; $display("FAIL stall_occ1: got %0d want 1", occupancy); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stall_ready1: got %b want 1", in_ready); end
    in_data = 32'hB;
    step();
    // Upstream keeps offering a third word that must not be taken.
    in_data = 32'hC;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (occupancy !== 2'd2) begin n_err++; $display("FAIL stall_occ2[%0d]: got %0d want 2", i, occupancy); end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready0[%0d]: got %b want 0", i, in_ready); end
      n_cmp++; if (out_data !== 32'hA) begin n_err++; $display("FAIL stall_hold[%0d]: got %h want a", i, out_data); end
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid[%0d]: got %b want 1", i, out_valid); end
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_cmp++; if (out_data !== 32'hA) begin n_err++; $display("FAIL release_first: got %h want a", out_data); end
    step();
    n_cmp++; if (out_data !== 32'hB) begin n_err++; $display("FAIL release_second: got %h want b", out_data); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL release_ready: got %b want 1", in_ready); end
    n_cmp++; if (occupancy !== 2'd1) begin n_err++; $display("FAIL release_occ: got %0d want 1", occupancy); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL release_empty: got %b want 0", out_valid); end
  endtask

  task automatic test_simultaneous();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h44;
    step();
    n_cmp++; if (out_data !== 32'h44) begin n_err++; $display("FAIL simul_head: got %h want 44", out_data); end
    in_data   = 32'h55;
    out_ready = 1'b1;
    step();
    n_cmp++; if (out_data !== 32'h55) begin n_err++; $display("FAIL simul_data: got %h want 55", out_data); end
    n_cmp++; if (occupancy !== 2'd1) begin n_err++; $display("FAIL simul_occ: got %0d want 1", occupancy); end
    in_valid = 1'b0;
    step();
    n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL simul_drain: got %0d want 0", occupancy); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h11;
    step();
    in_data = 32'h22;
    step();
    n_cmp++; if (occupancy !== 2'd2) begin n_err++; $display("FAIL flush_pre_occ: got %0d want 2", occupancy); end
    flush   = 1'b1;
    in_data = 32'h99;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_full_valid: got %b want 0", out_valid); end
    n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL flush_full_occ: got %0d want 0", occupancy); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_full_ready: got %b want 1", in_ready); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_no_leak: got %b want 0", out_valid); end
    // Flush in BUSY while an in-fire happens: that word is dropped too.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h12;
    step();
    flush   = 1'b1;
    in_data = 32'h98;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_busy_valid: got %b want 0", out_valid); end
    n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL flush_busy_occ: got %0d want 0", occupancy); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_busy_leak: got %b want 0", out_valid); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h31;
    step();
    in_data = 32'h32;
    step();
    n_cmp++; if (occupancy !== 2'd2) begin n_err++; $display("FAIL areset_pre_occ: got %0d want 2", occupancy); end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL areset_ready: got %b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL areset_valid: got %b want 0", out_valid); end
    n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL areset_occ: got %0d want 0", occupancy); end
    n_cmp++; if (out_data !== 32'h0) begin n_err++; $display("FAIL areset_data: got %h want 0", out_data); end
    in_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    step();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL areset_rel_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL areset_rel_valid: got %b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_stall_absorb();
    test_simultaneous();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
